// File: rtl/secuenciador_multiciclo_if.sv
// Bus bundle for the multicycle sequencer: instruction fetch, data access,
// control-unit enables and the status outputs.
interface secuenciador_multiciclo_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        dmem_req;
  logic        dmem_ack;
  logic        uc_wre;
  logic [3:0]  uc_wme;
  logic        wre;
  logic [3:0]  wme;
  logic        pc_we;
  logic [2:0]  estado;
  logic        illegal;
  logic [31:0] instret;

  modport master (
    output imem_req, ir, dmem_req, wre, wme, pc_we, estado, illegal, instret,
    input  imem_ack, imem_rdata, dmem_ack, uc_wre, uc_wme
  );

  modport slave (
    input  imem_req, ir, dmem_req, wre, wme, pc_we, estado, illegal, instret,
    output imem_ack, imem_rdata, dmem_ack, uc_wre, uc_wme
  );
endinterface

// File: rtl/secuenciador_multiciclo.sv
// Multicycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Gates control-unit write enables by phase, strobes the PC once per retired
// instruction, counts retirements and traps permanently on an unknown opcode.
module secuenciador_multiciclo (
  input  logic                          clk,
  input  logic                          rst_n,
  secuenciador_multiciclo_if.master     bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;

  logic        op_legal;
  logic        is_load, is_store, is_branch;
  logic        imem_req_c, dmem_req_c, wre_c, pc_we_c;
  logic [3:0]  wme_c;

  // Opcode classification of the instruction register
  always_comb begin
    case (ir_q[6:0])
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
    is_load   = (ir_q[6:0] == OP_LOAD);
    is_store  = (ir_q[6:0] == OP_STORE);
    is_branch = (ir_q[6:0] == OP_BRANCH);
  end

  // Next-state and phase-gated outputs, all decoded from the registered state
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    illegal_d  = illegal_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    wre_c      = 1'b0;
    wme_c      = '0;
    pc_we_c    = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (op_legal) begin
          state_d = EXEC;
        end else begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end
      end
      EXEC: begin
        if (is_load || is_store) begin
          state_d = MEM;
        end else if (is_branch) begin
          pc_we_c = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req_c = 1'b1;
        if (is_store) wme_c = bus.uc_wme;
        if (bus.dmem_ack) begin
          if (is_store) begin
            pc_we_c = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        wre_c   = bus.uc_wre;
        pc_we_c = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        illegal_d = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    instret_d = pc_we_c ? instret_q + 32'd1 : instret_q;
  end

  // State, instruction register, sticky trap flag and retirement counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ir_q      <= 32'h0000_0013;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset sits in FETCH, so the fetch request is also held off by rst_n itself
  assign bus.imem_req = imem_req_c & rst_n;
  assign bus.dmem_req = dmem_req_c;
  assign bus.wre      = wre_c;
  assign bus.wme      = wme_c;
  assign bus.pc_we    = pc_we_c;
  assign bus.ir       = ir_q;
  assign bus.estado   = state_q;
  assign bus.illegal  = illegal_q;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_secuenciador_multiciclo.sv
// Scoreboard bench for secuenciador_multiciclo: random instruction stream with
// random memory wait states, reference trace built from the phase rules.
module tb_secuenciador_multiciclo;

  localparam int unsigned K_BRANCH = 0;
  localparam int unsigned K_ALU    = 1;
  localparam int unsigned K_LOAD   = 2;
  localparam int unsigned K_STORE  = 3;

  typedef struct {
    logic [31:0] instr;
    int unsigned kind;
    int unsigned iwait;
    int unsigned dwait;
    logic        uwre;
    logic [3:0]  uwme;
    logic [31:0] instret_before;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  secuenciador_multiciclo_if bus ();

  secuenciador_multiciclo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  item_t       iq[$];
  item_t       sb[$];
  item_t       cur;
  item_t       mexp;
  logic [2:0]  tr[$];
  logic [2:0]  ex[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned icnt = 0;
  int unsigned dcnt = 0;
  int unsigned dcycles = 0;
  bit          busy = 0;
  bit          mon_en = 0;
  bit          wre_bad = 0;
  bit          wme_bad = 0;
  bit          idle_bad = 0;
  bit          trace_ok;
  logic [3:0]  exp_wme;
  logic [31:0] model_instret = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after the item's wait count, plus spurious acks
  always @(posedge clk) begin
    #1;
    bus.imem_ack   = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    if (!rst_n) begin
      icnt = 0;
      dcnt = 0;
    end else begin
      if (bus.imem_req) begin
        if (iq.size() > 0) begin
          busy = 1;
          if (icnt == iq[0].iwait) begin
            cur            = iq.pop_front();
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = cur.instr;
            bus.uc_wre     = cur.uwre;
            bus.uc_wme     = cur.uwme;
            icnt = 0;
            dcnt = 0;
          end else begin
            icnt++;
          end
        end
      end else if ($urandom_range(3) == 0) begin
        bus.imem_ack = 1'b1;
      end
      if (bus.dmem_req) begin
        if (dcnt == cur.dwait) begin
          bus.dmem_ack = 1'b1;
          dcnt = 0;
        end else begin
          dcnt++;
        end
      end else if ($urandom_range(3) == 0) begin
        bus.dmem_ack = 1'b1;
      end
    end
  end

  // Monitor: collects the state trace of each instruction, checks at retirement
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      tr.delete();
      dcycles = 0;
      wre_bad = 0;
      wme_bad = 0;
    end else if (busy) begin
      tr.push_back(bus.estado);
      if (bus.dmem_req === 1'b1) dcycles++;
      exp_wme = (bus.dmem_req === 1'b1 && sb.size() > 0 && sb[0].kind == K_STORE) ? sb[0].uwme : 4'b0000;
      if (bus.wme !== exp_wme) wme_bad = 1;
      if (bus.pc_we !== 1'b1 && bus.wre !== 1'b0) wre_bad = 1;
      if (bus.pc_we === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_retire", 32'd1, 32'd0);
        end else begin
          mexp = sb.pop_front();
          ex.delete();
          for (int unsigned i = 0; i <= mexp.iwait; i++) ex.push_back(3'd0);
          ex.push_back(3'd1);
          ex.push_back(3'd2);
          if (mexp.kind == K_LOAD || mexp.kind == K_STORE)
            for (int unsigned i = 0; i <= mexp.dwait; i++) ex.push_back(3'd3);
          if (mexp.kind == K_ALU || mexp.kind == K_LOAD) ex.push_back(3'd4);
          trace_ok = (tr.size() == ex.size());
          if (trace_ok)
            for (int unsigned i = 0; i < ex.size(); i++)
              if (tr[i] !== ex[i]) trace_ok = 0;
          checks++;
          if (!trace_ok) begin
            failures++;
            $display("FAIL trace instr=%h: got %0d cycles expected %0d cycles", mexp.instr, tr.size(), ex.size());
          end
          chk("ir", bus.ir, mexp.instr);
          chk("wre_retire", {31'd0, bus.wre},
              {31'd0, (mexp.kind == K_ALU || mexp.kind == K_LOAD) ? mexp.uwre : 1'b0});
          chk("wre_outside_wb", {31'd0, wre_bad}, 32'd0);
          chk("wme_gating", {31'd0, wme_bad}, 32'd0);
          chk("dmem_req_cycles", dcycles,
              (mexp.kind == K_LOAD || mexp.kind == K_STORE) ? mexp.dwait + 1 : 0);
          chk("instret_before", bus.instret, mexp.instret_before);
        end
        tr.delete();
        dcycles = 0;
        wre_bad = 0;
        wme_bad = 0;
        busy = 0;
      end
    end else begin
      if (bus.pc_we !== 1'b0 || bus.dmem_req !== 1'b0 || bus.wre !== 1'b0 || bus.wme !== 4'b0000)
        idle_bad = 1;
    end
  end

  task automatic issue(input logic [31:0] instr, input int unsigned kind, input int unsigned iw,
                       input int unsigned dw, input logic uwre, input logic [3:0] uwme);
    item_t it;
    it.instr          = instr;
    it.kind           = kind;
    it.iwait          = iw;
    it.dwait          = dw;
    it.uwre           = uwre;
    it.uwme           = uwme;
    it.instret_before = model_instret;
    model_instret     = model_instret + 32'd1;
    iq.push_back(it);
    sb.push_back(it);
  endtask

  task automatic issue_random();
    logic [6:0]  alu_ops [6] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    logic [31:0] instr;
    int unsigned kind, iw, dw;
    kind  = $urandom_range(3);
    instr = $urandom;
    case (kind)
      K_BRANCH: instr[6:0] = 7'b1100011;
      K_LOAD:   instr[6:0] = 7'b0000011;
      K_STORE:  instr[6:0] = 7'b0100011;
      default:  instr[6:0] = alu_ops[$urandom_range(5)];
    endcase
    iw = ($urandom_range(1) == 0) ? 0 : $urandom_range(4);
    dw = ($urandom_range(1) == 0) ? 0 : $urandom_range(4);
    issue(instr, kind, iw, dw, 1'($urandom_range(1)), 4'($urandom_range(15)));
  endtask

  task automatic drain(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending expected 0 pending", name, sb.size());
      sb.delete();
      iq.delete();
    end
  endtask

  initial begin
    int unsigned n;
    bit          act_bad;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ack   = 1'b0;
    bus.uc_wre     = 1'b0;
    bus.uc_wme     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_estado",   {29'd0, bus.estado}, 32'd0);
    chk("rst_ir",       bus.ir, 32'h0000_0013);
    chk("rst_instret",  bus.instret, 32'd0);
    chk("rst_illegal",  {31'd0, bus.illegal}, 32'd0);
    chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_outputs",  {26'd0, bus.wre, bus.wme, bus.pc_we}, 32'd0);

    // Directed vectors followed by a random stream
    issue(32'hfe010113, K_ALU,    0, 0, 1'b1, 4'b1111);
    issue(32'hfe042023, K_STORE,  0, 3, 1'b1, 4'b1111);
    issue(32'hfef710e3, K_BRANCH, 0, 0, 1'b1, 4'b1111);
    for (int i = 0; i < 60; i++) issue_random();
    @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1;
    drain("stream", 5000);

    // Counter wrap from all-ones on one ADD retirement
    repeat (2) @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #2 release dut.instret_q;
    model_instret = 32'hFFFF_FFFF;
    issue(32'h00f707b3, K_ALU, 1, 0, 1'b1, 4'b0000);
    drain("wrap", 200);
    @(negedge clk);
    chk("instret_wrap", bus.instret, 32'd0);

    // Reset while a load waits in MEM
    issue(32'h0000_2083, K_LOAD, 0, 40, 1'b1, 4'b0000);
    n = 0;
    while (bus.dmem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mem_reached", {31'd0, bus.dmem_req}, 32'd1);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("abort_ir",       bus.ir, 32'h0000_0013);
    chk("abort_instret",  bus.instret, 32'd0);
    chk("abort_imem_req", {31'd0, bus.imem_req}, 32'd0);
    iq.delete();
    sb.delete();
    busy = 0;
    model_instret = '0;
    repeat (2) @(negedge clk);
    issue(32'h00f707b3, K_ALU, 0, 0, 1'b1, 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1;
    @(negedge clk);
    chk("refetch_imem_req", {31'd0, bus.imem_req}, 32'd1);
    drain("after_reset", 200);

    // Illegal opcode traps for good
    begin
      item_t it;
      it.instr = 32'hffffffff; it.kind = K_ALU; it.iwait = 1; it.dwait = 0;
      it.uwre = 1'b1; it.uwme = 4'b1111; it.instret_before = model_instret;
      iq.push_back(it);
    end
    n = 0;
    while (bus.illegal !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("trap_illegal", {31'd0, bus.illegal}, 32'd1);
    chk("trap_estado",  {29'd0, bus.estado}, 32'd5);
    act_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || bus.wre !== 1'b0 ||
          bus.wme !== 4'b0000 || bus.pc_we !== 1'b0 || bus.estado !== 3'd5 || bus.illegal !== 1'b1)
        act_bad = 1;
    end
    chk("trap_quiet",   {31'd0, act_bad}, 32'd0);
    chk("trap_instret", bus.instret, model_instret);
    chk("trap_ir",      bus.ir, 32'hffffffff);
    chk("idle_quiet",   {31'd0, idle_bad}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/secuenciador_multiciclo.md
SECUENCIADOR_MULTICICLO -- requirements
Module: secuenciador_multiciclo

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-004 SHALL have port imem_ack, input, 1 bit: fetch complete; imem_rdata valid this cycle.
REQ-005 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-006 SHALL have port ir, output, 32 bits: instruction register; drives opcode/funct3/funct7 of Unidad_de_Control.
REQ-007 SHALL have port dmem_req, output, 1 bit: data memory access request.
REQ-008 SHALL have port dmem_ack, input, 1 bit: data access complete.
REQ-009 SHALL have port uc_wre, input, 1 bit: register write enable from Unidad_de_Control.
REQ-010 SHALL have port uc_wme, input, 4 bits: byte write enables from Unidad_de_Control.
REQ-011 SHALL have port wre, output, 1 bit: gated register-file write enable.
REQ-012 SHALL have port wme, output, 4 bits: gated data-memory byte write enables.
REQ-013 SHALL have port pc_we, output, 1 bit: PC update strobe.
REQ-014 SHALL have port estado, output, 3 bits: current state code.
REQ-015 SHALL have port illegal, output, 1 bit: sticky illegal-opcode flag.
REQ-016 SHALL have port instret, output, 32 bits: retired-instruction counter.

Function
REQ-017 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 unreachable, recover to FETCH.
REQ-018 FETCH: imem_req=1, held until imem_ack; on imem_ack capture ir<=imem_rdata, next DECODE; imem_req=0 the cycle after ack.
REQ-019 DECODE: one cycle; ir[6:0] not in {0110011,0010011,0000011,0100011,1100011,0110111,0010111,1101111,1100111} -> TRAP, else EXEC.
REQ-020 EXEC: one cycle; opcode 0000011 or 0100011 -> MEM; 1100011 -> pc_we=1 this cycle, retire, next FETCH; all others -> WB.
REQ-021 MEM: dmem_req=1 held until dmem_ack; for stores wme=uc_wme every MEM cycle; on ack, store -> pc_we=1, retire, next FETCH; load -> WB.
REQ-022 WB: one cycle; wre=uc_wre, pc_we=1, retire, next FETCH.
REQ-023 wre SHALL be 0 outside WB; wme SHALL be 4'b0000 outside MEM and for loads.
REQ-024 pc_we SHALL pulse exactly one cycle per retired instruction; instret increments by 1 on that same edge, wrapping 0xFFFFFFFF->0.
REQ-025 TRAP: illegal=1; imem_req, dmem_req, wre, wme, pc_we all 0; remains until reset.
REQ-026 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-027 Latency with same-cycle ack: branch 3 cycles, ALU/LUI/AUIPC/JAL/JALR 4, store 4, load 5; each extra wait cycle adds 1.
REQ-028 imem_req, dmem_req, wre, wme, pc_we SHALL decode from registered state (plus uc_wre/uc_wme gating and acks); no other combinational input paths.

Reset
REQ-029 rst_n=0 SHALL immediately force: state FETCH, ir=32'h00000013, instret=0, illegal=0; wre, wme, pc_we, dmem_req=0; while rst_n=0, imem_req=0.
REQ-030 Reset mid-operation (any state, any req high) SHALL abort the access without completion; first fetch starts the cycle after rst_n rises.

Verification
REQ-031 ir<-32'hfe010113 (ADDI), imem_ack same cycle, uc_wre=1 -> estado 0,1,2,4; wre=1 and pc_we=1 only in WB; instret=1.
REQ-032 ir<-32'hfe042023 (SW), uc_wme=4'b1111, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, wme=1111 those cycles, wre never 1, pc_we on ack cycle.
REQ-033 ir<-32'hfef710e3 (BNE) -> estado 0,1,2 then 0; pc_we=1 in EXEC; wre=0, wme=0, dmem_req never 1.
REQ-034 ir<-32'hffffffff -> DECODE then TRAP; illegal=1; imem_req stays 0 for 20 cycles; instret unchanged.
REQ-035 rst_n=0 during MEM with dmem_req=1 -> dmem_req=0 before next clock edge, ir=32'h00000013, instret=0; after release, imem_req=1 next cycle.
REQ-036 Preload instret=32'hFFFFFFFF via 2^32-1 retirements or force, retire one ADD (32'h00f707b3) -> instret=0.
